// File: rtl/if_fetch_queue.sv
// if_fetch_queue: sequential instruction fetch with a small {pc, inst} FIFO and redirect/drop handling
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    input  logic        mem_stall,
    input  logic [31:0] mem_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    typedef enum logic {FETCH, DROP} state_t;
    state_t      r_state, w_state_nxt;
    logic [31:0] r_fetch_pc, r_hold;
    logic [31:0] r_pc_q [DEPTH];
    logic [31:0] r_inst_q [DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [PW:0] r_cnt;
    logic        w_acc, w_push, w_pop;
    logic [31:0] w_redir;
    assign w_redir   = redir_pc & ~32'd3;
    assign w_acc     = mem_read && !mem_stall;
    assign w_push    = r_state == FETCH && w_acc && !redir_valid;
    assign w_pop     = dec_valid && dec_ready;
    assign dec_valid = r_cnt != '0;
    assign dec_inst  = dec_valid ? r_inst_q[r_rp] : 32'h0000_0013;
    assign dec_pc    = dec_valid ? r_pc_q[r_rp] : 32'h0;
    // Request generation: the count cannot grow without an accept, so mem_read stays stable while pending
    always_comb begin
        mem_read    = !rst && (r_state == DROP || r_cnt != FULL);
        mem_addr    = r_state == DROP ? r_hold : r_fetch_pc;
        w_state_nxt = r_state;
        if (r_state == FETCH && redir_valid && mem_read && mem_stall)
            w_state_nxt = DROP;
        else if (r_state == DROP && w_acc)
            w_state_nxt = FETCH;
    end
    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= FETCH;
        else     r_state <= w_state_nxt;
    end
    // Fetch PC, FIFO pointers and count; a redirect flushes and overrides push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_cnt      <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
        end else if (redir_valid) begin
            r_fetch_pc <= w_redir;
            r_cnt      <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
        end else begin
            if (w_push) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            r_cnt <= r_cnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        end
    end
    // Capture the outstanding address so DROP can keep presenting it after fetch_pc moves
    always_ff @(posedge clk) begin
        if (r_state == FETCH) r_hold <= r_fetch_pc;
    end
    // FIFO storage, no reset needed since validity comes from the count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_q[r_wp]   <= mem_addr;
            r_inst_q[r_wp] <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed checks of fetch, backpressure, redirect, drop and reset
module tb_if_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic        mem_stall = 1'b0;
    logic [31:0] mem_rdata;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_ready = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    int          n_chk = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          acc_base;

    if_fetch_queue #(.RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_addr(mem_addr), .mem_stall(mem_stall), .mem_rdata(mem_rdata),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_ready(dec_ready),
        .redir_valid(redir_valid), .redir_pc(redir_pc)
    );

    always #5 clk = ~clk;

    // Memory model: the word at address A is A
    assign mem_rdata = mem_addr;

    // Count accepts mid-cycle, away from the clock edge
    always @(negedge clk) if (mem_read && !mem_stall) n_acc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redir_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_read", {31'b0, mem_read}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_valid", {31'b0, dec_valid}, 32'd0);
        chk("rst_inst", dec_inst, 32'h13);
        chk("rst_pc", dec_pc, 32'h0);
        // 1: streaming fetch
        rst = 1'b0; dec_ready = 1'b1;
        #1;
        chk("t1_read", {31'b0, mem_read}, 32'd1);
        chk("t1_addr0", mem_addr, 32'h0);
        tick();
        chk("t1_pc0", dec_pc, 32'h0);
        chk("t1_addr4", mem_addr, 32'h4);
        tick();
        chk("t1_pc4", dec_pc, 32'h4);
        chk("t1_inst4", dec_inst, 32'h4);
        tick();
        chk("t1_pc8", dec_pc, 32'h8);
        chk("t1_addrC", mem_addr, 32'hC);
        // 2: backpressure fills the FIFO
        dec_ready = 1'b0;
        do_reset();
        acc_base = n_acc;
        for (int i = 0; i < 10; i++) tick();
        chk("t2_accepts", n_acc - acc_base, 32'd4);
        chk("t2_read_full", {31'b0, mem_read}, 32'd0);
        chk("t2_head", dec_pc, 32'h0);
        dec_ready = 1'b1;
        tick();
        chk("t2_pop4", dec_pc, 32'h4);
        chk("t2_resume", mem_addr, 32'h10);
        chk("t2_read_on", {31'b0, mem_read}, 32'd1);
        tick();
        chk("t2_pop8", dec_pc, 32'h8);
        tick();
        chk("t2_popC", dec_pc, 32'hC);
        tick();
        chk("t2_pop10", dec_pc, 32'h10);
        // 3: redirect while a request is stalled
        do_reset();
        tick();
        tick();
        chk("t3_addr8", mem_addr, 32'h8);
        mem_stall = 1'b1; redir_valid = 1'b1; redir_pc = 32'h103;
        tick();
        redir_valid = 1'b0;
        chk("t3_flush", {31'b0, dec_valid}, 32'd0);
        chk("t3_hold1", mem_addr, 32'h8);
        chk("t3_read", {31'b0, mem_read}, 32'd1);
        tick();
        chk("t3_hold2", mem_addr, 32'h8);
        tick();
        chk("t3_hold3", mem_addr, 32'h8);
        mem_stall = 1'b0;
        tick();
        chk("t3_dropped", {31'b0, dec_valid}, 32'd0);
        chk("t3_newaddr", mem_addr, 32'h100);
        tick();
        chk("t3_pc", dec_pc, 32'h100);
        chk("t3_inst", dec_inst, 32'h100);
        // 4: redirect coinciding with accept and pop
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        chk("t4_addr10", mem_addr, 32'h10);
        chk("t4_headC", dec_pc, 32'hC);
        redir_valid = 1'b1; redir_pc = 32'h40;
        tick();
        redir_valid = 1'b0;
        chk("t4_flush", {31'b0, dec_valid}, 32'd0);
        chk("t4_addr40", mem_addr, 32'h40);
        tick();
        chk("t4_pc40", dec_pc, 32'h40);
        // 5: two redirects during DROP
        do_reset();
        tick();
        mem_stall = 1'b1; redir_valid = 1'b1; redir_pc = 32'h200;
        tick();
        chk("t5_hold", mem_addr, 32'h4);
        redir_pc = 32'h300;
        tick();
        chk("t5_hold2", mem_addr, 32'h4);
        redir_valid = 1'b0; mem_stall = 1'b0;
        tick();
        chk("t5_addr300", mem_addr, 32'h300);
        chk("t5_empty", {31'b0, dec_valid}, 32'd0);
        tick();
        chk("t5_pc300", dec_pc, 32'h300);
        // 6: reset with a pending request
        dec_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        chk("t6_full", {31'b0, mem_read}, 32'd0);
        dec_ready = 1'b1; mem_stall = 1'b1;
        tick();
        chk("t6_pending", {31'b0, mem_read}, 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_valid", {31'b0, dec_valid}, 32'd0);
        chk("t6_inst", dec_inst, 32'h13);
        chk("t6_read", {31'b0, mem_read}, 32'd0);
        rst = 1'b0; mem_stall = 1'b0;
        #1;
        chk("t6_restart", mem_addr, 32'h0);
        tick();
        chk("t6_pc0", dec_pc, 32'h0);
        // 7: PC wraps modulo 2^32 after a misaligned redirect target
        redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFF;
        tick();
        redir_valid = 1'b0;
        chk("t7_align", mem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t7_pc", dec_pc, 32'hFFFF_FFFC);
        chk("t7_wrap", mem_addr, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
